// File: rtl/tcdm_xbar_pkg.sv
// Shared types and helpers for the TCDM bank arbiter.
// Contents: word/byte-enable typedefs, per-port request payload struct,
// the out-of-range read pattern and the word-offset helper used for
// bank/word index decoding.
package tcdm_xbar_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [BE_W-1:0]   be_t;

  // Payload forwarded from the winning requester to its bank.
  typedef struct packed {
    logic  wen;
    be_t   be;
    word_t data;
  } tcdm_req_t;

  localparam word_t OOB_RDATA = 32'hDEADBEEF;

  // Word offset from the TCDM base; low bits select the bank, the rest the word.
  function automatic word_t word_offset(input word_t add, input word_t base);
    return (add - base) >> 2;
  endfunction

endpackage

// File: rtl/tcdm_rr_arb_node.sv
// Per-bank round-robin arbitration node.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   core_prio_i   1: request on the highest port beats round-robin
//   req_i         candidate requests targeting this bank
//   gnt_c         one-hot grant (combinational)
//   win_idx_c     index of the granted port (combinational)
//   win_valid_c   a grant was issued this cycle (combinational)
module tcdm_rr_arb_node #(
  parameter  int unsigned N_IN = 5,
  localparam int unsigned IW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            core_prio_i,
  input  logic [N_IN-1:0] req_i,
  output logic [N_IN-1:0] gnt_c,
  output logic [IW-1:0]   win_idx_c,
  output logic            win_valid_c
);

  logic [IW-1:0] rr_q, rr_d;
  logic          rr_grant;
  logic [IW:0]   cand;

  // Winner selection: core priority override, else first request from rr_q upward.
  always_comb begin
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    rr_grant    = 1'b0;
    cand        = '0;
    if (core_prio_i && req_i[N_IN-1]) begin
      win_valid_c = 1'b1;
      win_idx_c   = IW'(N_IN - 1);
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        // rr_q + i stays below 2*N_IN, so one conditional subtract wraps it.
        cand = (IW+1)'(rr_q) + (IW+1)'(i);
        if (cand >= (IW+1)'(N_IN)) begin
          cand = cand - (IW+1)'(N_IN);
        end
        if (!win_valid_c && req_i[IW'(cand)]) begin
          win_valid_c = 1'b1;
          win_idx_c   = IW'(cand);
          rr_grant    = 1'b1;
        end
      end
    end
    gnt_c = win_valid_c ? (N_IN'(1) << win_idx_c) : '0;
  end

  // Pointer advances past the winner only on round-robin grants.
  always_comb begin
    rr_d = rr_q;
    if (rr_grant) begin
      rr_d = (win_idx_c == IW'(N_IN - 1)) ? '0 : win_idx_c + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Word-interleaved multi-bank TCDM arbiter between N_IN requesters
// (accelerator ports 0..N_IN-2, core port N_IN-1).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_i/add_i/wen_i/be_i/data_i  requester side (wen 1 = read)
//   gnt_o                       combinational grant
//   r_valid_o/r_data_o/oob_o    response one cycle after grant
//   bank_*_o, bank_r_data_i     bank SRAM side, 1-cycle read latency
//   clear_i, conflict_cnt_o     saturating count of cycles with a stalled request
module tcdm_bank_arbiter
  import tcdm_xbar_pkg::*;
#(
  parameter  int unsigned N_IN       = 5,
  parameter  int unsigned N_BANKS    = 8,
  parameter  int unsigned BANK_WORDS = 6144,
  parameter  logic [31:0] BASE_ADDR  = 32'h1c010000,
  parameter  bit          CORE_PRIO  = 1'b0,
  localparam int unsigned BW         = $clog2(N_BANKS),
  localparam int unsigned BAW        = $clog2(BANK_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_IN-1:0]               req_i,
  input  logic [N_IN-1:0][31:0]         add_i,
  input  logic [N_IN-1:0]               wen_i,
  input  logic [N_IN-1:0][3:0]          be_i,
  input  logic [N_IN-1:0][31:0]         data_i,
  output logic [N_IN-1:0]               gnt_o,
  output logic [N_IN-1:0]               r_valid_o,
  output logic [N_IN-1:0][31:0]         r_data_o,
  output logic [N_IN-1:0]               oob_o,
  output logic [N_BANKS-1:0]            bank_req_o,
  output logic [N_BANKS-1:0][BAW-1:0]   bank_add_o,
  output logic [N_BANKS-1:0]            bank_wen_o,
  output logic [N_BANKS-1:0][3:0]       bank_be_o,
  output logic [N_BANKS-1:0][31:0]      bank_data_o,
  input  logic [N_BANKS-1:0][31:0]      bank_r_data_i,
  input  logic                          clear_i,
  output logic [31:0]                   conflict_cnt_o
);

  localparam int unsigned IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [32:0] SPAN = 33'(4 * N_BANKS * BANK_WORDS);

  logic [N_IN-1:0]                in_range;
  logic [N_IN-1:0][BW-1:0]        bank_idx;
  logic [N_IN-1:0][BAW-1:0]       word_idx;
  tcdm_req_t [N_IN-1:0]           port_req;

  logic [N_BANKS-1:0][N_IN-1:0]   cand_req;
  logic [N_BANKS-1:0][N_IN-1:0]   bank_gnt;
  logic [N_BANKS-1:0][IW-1:0]     bank_win;
  logic [N_BANKS-1:0]             bank_act;

  logic [N_IN-1:0]                rvalid_q, rvalid_d;
  logic [N_IN-1:0]                roob_q, roob_d;
  logic [N_IN-1:0]                rread_q, rread_d;
  logic [N_IN-1:0][BW-1:0]        rbank_q, rbank_d;

  logic                           conflict;
  logic [31:0]                    conflict_cnt_q, conflict_cnt_d;

  // Address decode and per-port payload packing.
  always_comb begin
    for (int unsigned p = 0; p < N_IN; p++) begin
      in_range[p] = (add_i[p] >= BASE_ADDR) && ({1'b0, add_i[p] - BASE_ADDR} < SPAN);
      bank_idx[p] = BW'(word_offset(add_i[p], BASE_ADDR));
      word_idx[p] = BAW'(word_offset(add_i[p], BASE_ADDR) >> BW);
      port_req[p] = '{wen: wen_i[p], be: be_i[p], data: data_i[p]};
    end
  end

  // Candidate matrix: in-range requests per target bank.
  always_comb begin
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      for (int unsigned p = 0; p < N_IN; p++) begin
        cand_req[b][p] = req_i[p] && in_range[p] && (bank_idx[p] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    tcdm_rr_arb_node #(
      .N_IN (N_IN)
    ) u_node (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_prio_i (CORE_PRIO),
      .req_i       (cand_req[b]),
      .gnt_c       (bank_gnt[b]),
      .win_idx_c   (bank_win[b]),
      .win_valid_c (bank_act[b])
    );
  end

  // Winner's fields drive each bank.
  always_comb begin
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      bank_req_o[b]  = bank_act[b];
      bank_add_o[b]  = word_idx[bank_win[b]];
      bank_wen_o[b]  = port_req[bank_win[b]].wen;
      bank_be_o[b]   = port_req[bank_win[b]].be;
      bank_data_o[b] = port_req[bank_win[b]].data;
    end
  end

  // Out-of-range requests are accepted at once; in-range ones via their bank.
  always_comb begin
    gnt_o = req_i & ~in_range;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      gnt_o = gnt_o | bank_gnt[b];
    end
    conflict = |(req_i & ~gnt_o);
  end

  // Response tracking captured at grant.
  always_comb begin
    rvalid_d = gnt_o;
    roob_d   = ~in_range;
    rread_d  = wen_i;
    rbank_d  = bank_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      roob_q   <= '0;
      rread_q  <= '0;
      rbank_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      roob_q   <= roob_d;
      rread_q  <= rread_d;
      rbank_q  <= rbank_d;
    end
  end

  // Read data is steered from the bank the port was granted on last cycle.
  always_comb begin
    for (int unsigned p = 0; p < N_IN; p++) begin
      r_data_o[p] = '0;
      if (rvalid_q[p]) begin
        if (roob_q[p]) begin
          r_data_o[p] = OOB_RDATA;
        end else if (rread_q[p]) begin
          r_data_o[p] = bank_r_data_i[rbank_q[p]];
        end
      end
    end
  end

  assign r_valid_o = rvalid_q;
  assign oob_o     = rvalid_q & roob_q;

  // Saturating conflict counter; clear dominates.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (clear_i) begin
      conflict_cnt_d = '0;
    end else if (conflict && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter: a vector table for the main
// datapath plus hand-written sequences for clear, saturation, reset and
// core priority.
module tb_tcdm_bank_arbiter;

  localparam int unsigned NI  = 3;
  localparam int unsigned NB  = 4;
  localparam int unsigned BWD = 16;
  localparam int unsigned BAW = 4;
  localparam logic [31:0] A   = 32'h1c010000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT0 (round-robin) signals
  logic [NI-1:0]          req, wen, gnt, rvalid, oob;
  logic [NI-1:0][31:0]    add, wdata, rdata;
  logic [NI-1:0][3:0]     be;
  logic [NB-1:0]          breq, bwen;
  logic [NB-1:0][BAW-1:0] badd;
  logic [NB-1:0][3:0]     bbe;
  logic [NB-1:0][31:0]    bwdata;
  logic [NB-1:0][31:0]    brdata = '0;
  logic                   clr;
  logic [31:0]            cnt;

  // DUT1 (core priority) signals
  logic [NI-1:0]          req1, wen1, gnt1, rvalid1, oob1;
  logic [NI-1:0][31:0]    add1, wdata1, rdata1;
  logic [NI-1:0][3:0]     be1;
  logic [NB-1:0]          breq1, bwen1;
  logic [NB-1:0][BAW-1:0] badd1;
  logic [NB-1:0][3:0]     bbe1;
  logic [NB-1:0][31:0]    bwdata1;
  logic [NB-1:0][31:0]    brdata1;
  logic                   clr1;
  logic [31:0]            cnt1;

  assign brdata1 = '0;

  tcdm_bank_arbiter #(
    .N_IN(NI), .N_BANKS(NB), .BANK_WORDS(BWD), .BASE_ADDR(A), .CORE_PRIO(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
    .data_i(wdata), .gnt_o(gnt), .r_valid_o(rvalid), .r_data_o(rdata), .oob_o(oob),
    .bank_req_o(breq), .bank_add_o(badd), .bank_wen_o(bwen), .bank_be_o(bbe),
    .bank_data_o(bwdata), .bank_r_data_i(brdata), .clear_i(clr), .conflict_cnt_o(cnt)
  );

  tcdm_bank_arbiter #(
    .N_IN(NI), .N_BANKS(NB), .BANK_WORDS(BWD), .BASE_ADDR(A), .CORE_PRIO(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req1), .add_i(add1), .wen_i(wen1), .be_i(be1),
    .data_i(wdata1), .gnt_o(gnt1), .r_valid_o(rvalid1), .r_data_o(rdata1), .oob_o(oob1),
    .bank_req_o(breq1), .bank_add_o(badd1), .bank_wen_o(bwen1), .bank_be_o(bbe1),
    .bank_data_o(bwdata1), .bank_r_data_i(brdata1), .clear_i(clr1), .conflict_cnt_o(cnt1)
  );

  // Bank SRAM model for DUT0: 1-cycle read latency, byte-enabled writes.
  logic [31:0] mem [NB][BWD] = '{default: '0};
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (breq[b]) begin
        if (bwen[b]) begin
          brdata[b] <= mem[b][badd[b]];
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (bbe[b][k]) mem[b][badd[b]][8*k +: 8] <= bwdata[b][8*k +: 8];
          end
        end
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wen;
    logic [31:0] a0, a1, a2;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [2:0]  e_gnt;
    logic [3:0]  e_breq;
    logic [2:0]  e_rv;
    logic [2:0]  e_oob;
    logic [31:0] e_rd0, e_rd1, e_rd2;
    logic [31:0] e_cnt;
    int          ab;
    logic [3:0]  e_badd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    //            req     wen     a0            a1            a2            wd            be       gnt     breq     rv      oob     rd0           rd1           rd2           cnt    ab  badd
    vecs[0]  = '{3'b001, 3'b000, A+32'h4,      32'h0,        32'h0,        32'hA5A5A5A5, 4'hF,    3'b001, 4'b0010, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0,        32'd0, 1,  4'd0};
    vecs[1]  = '{3'b001, 3'b001, A+32'h4,      32'h0,        32'h0,        32'h0,        4'hF,    3'b001, 4'b0010, 3'b001, 3'b000, 32'h0,        32'h0,        32'h0,        32'd0, 1,  4'd0};
    vecs[2]  = '{3'b010, 3'b000, 32'h0,        A,            32'h0,        32'h11223344, 4'b0101, 3'b010, 4'b0001, 3'b001, 3'b000, 32'hA5A5A5A5, 32'h0,        32'h0,        32'd0, 0,  4'd0};
    vecs[3]  = '{3'b111, 3'b111, A,            A,            A,            32'h0,        4'hF,    3'b100, 4'b0001, 3'b010, 3'b000, 32'h0,        32'h0,        32'h0,        32'd0, 0,  4'd0};
    vecs[4]  = '{3'b111, 3'b111, A,            A,            A,            32'h0,        4'hF,    3'b001, 4'b0001, 3'b100, 3'b000, 32'h0,        32'h0,        32'h00220044, 32'd1, 0,  4'd0};
    vecs[5]  = '{3'b111, 3'b111, A,            A,            A,            32'h0,        4'hF,    3'b010, 4'b0001, 3'b001, 3'b000, 32'h00220044, 32'h0,        32'h0,        32'd2, 0,  4'd0};
    vecs[6]  = '{3'b111, 3'b111, A,            A,            A,            32'h0,        4'hF,    3'b100, 4'b0001, 3'b010, 3'b000, 32'h0,        32'h00220044, 32'h0,        32'd3, 0,  4'd0};
    vecs[7]  = '{3'b111, 3'b111, A,            A+32'h4,      A+32'h8,      32'h0,        4'hF,    3'b111, 4'b0111, 3'b100, 3'b000, 32'h0,        32'h0,        32'h00220044, 32'd4, 2,  4'd0};
    vecs[8]  = '{3'b101, 3'b111, A+32'h4,      32'h0,        32'h80000000, 32'h0,        4'hF,    3'b101, 4'b0010, 3'b111, 3'b000, 32'h00220044, 32'hA5A5A5A5, 32'h0,        32'd4, 1,  4'd0};
    vecs[9]  = '{3'b000, 3'b111, 32'h0,        32'h0,        32'h0,        32'h0,        4'hF,    3'b000, 4'b0000, 3'b101, 3'b100, 32'hA5A5A5A5, 32'h0,        32'hDEADBEEF, 32'd4, -1, 4'd0};
    vecs[10] = '{3'b111, 3'b101, 32'h1c00fffc, A+32'hFC,     A+32'h100,    32'hCAFEF00D, 4'hF,    3'b111, 4'b1000, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0,        32'd4, 3,  4'd15};
    vecs[11] = '{3'b010, 3'b010, 32'h0,        A+32'hFC,     32'h0,        32'h0,        4'hF,    3'b010, 4'b1000, 3'b111, 3'b101, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'd4, 3,  4'd15};
    vecs[12] = '{3'b000, 3'b111, 32'h0,        32'h0,        32'h0,        32'h0,        4'hF,    3'b000, 4'b0000, 3'b010, 3'b000, 32'h0,        32'hCAFEF00D, 32'h0,        32'd4, -1, 4'd0};

    rst_n = 1'b0;
    req = '0; wen = '0; add = '0; wdata = '0; be = '0; clr = 1'b0;
    req1 = '0; wen1 = '0; add1 = '0; wdata1 = '0; be1 = '0; clr1 = 1'b0;

    // Reset state
    step();
    step();
    chk("rst r_valid", 32'(rvalid), 32'h0);
    chk("rst oob", 32'(oob), 32'h0);
    chk("rst r_data0", rdata[0], 32'h0);
    chk("rst cnt", cnt, 32'h0);
    chk("rst gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    step();

    // Table-driven main function
    for (int i = 0; i < 13; i++) begin
      req = vecs[i].req;
      wen = vecs[i].wen;
      add[0] = vecs[i].a0;
      add[1] = vecs[i].a1;
      add[2] = vecs[i].a2;
      for (int p = 0; p < NI; p++) begin
        wdata[p] = vecs[i].wd;
        be[p]    = vecs[i].be;
      end
      #1;
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d bank_req", i), 32'(breq), 32'(vecs[i].e_breq));
      chk($sformatf("v%0d r_valid", i), 32'(rvalid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d oob", i), 32'(oob), 32'(vecs[i].e_oob));
      chk($sformatf("v%0d cnt", i), cnt, vecs[i].e_cnt);
      if (vecs[i].e_rv[0]) chk($sformatf("v%0d r_data0", i), rdata[0], vecs[i].e_rd0);
      if (vecs[i].e_rv[1]) chk($sformatf("v%0d r_data1", i), rdata[1], vecs[i].e_rd1);
      if (vecs[i].e_rv[2]) chk($sformatf("v%0d r_data2", i), rdata[2], vecs[i].e_rd2);
      if (vecs[i].ab >= 0) chk($sformatf("v%0d bank_add", i), 32'(badd[vecs[i].ab]), 32'(vecs[i].e_badd));
      step();
    end

    // Clear held with conflicts present
    req = 3'b111; wen = 3'b111; add[0] = A; add[1] = A; add[2] = A;
    clr = 1'b1;
    step();
    chk("clear cnt a", cnt, 32'h0);
    step();
    chk("clear cnt b", cnt, 32'h0);
    clr = 1'b0;
    step();
    chk("after clear cnt", cnt, 32'h1);

    // Saturation: preload the next count to all-ones, then keep conflicting
    force dut0.conflict_cnt_d = 32'hFFFFFFFF;
    step();
    release dut0.conflict_cnt_d;
    #1;
    chk("sat load", cnt, 32'hFFFFFFFF);
    step();
    chk("sat hold a", cnt, 32'hFFFFFFFF);
    step();
    chk("sat hold b", cnt, 32'hFFFFFFFF);
    clr = 1'b1;
    step();
    chk("sat clear", cnt, 32'h0);
    clr = 1'b0;

    // Reset mid-operation
    req = 3'b010;
    step();
    req = 3'b111;
    #1;
    chk("pre-rst gnt rr=2", 32'(gnt), 32'b100);
    chk("pre-rst r_valid", 32'(rvalid), 32'b010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst-mid r_valid", 32'(rvalid), 32'h0);
    req = '0;
    step();
    step();
    chk("rst-mid cnt", cnt, 32'h0);
    rst_n = 1'b1;
    step();
    chk("post-rst r_valid", 32'(rvalid), 32'h0);
    req = 3'b111;
    #1;
    chk("post-rst gnt rr=0", 32'(gnt), 32'b001);
    step();
    chk("post-rst r_valid grant", 32'(rvalid), 32'b001);
    req = '0;

    // Core priority on bank0 (DUT1)
    req1 = 3'b101; wen1 = 3'b111; add1[0] = A; add1[1] = A; add1[2] = A;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("prio gnt c%0d", k), 32'(gnt1), 32'b100);
      step();
    end
    chk("prio cnt", cnt1, 32'd3);
    chk("prio r_valid", 32'(rvalid1), 32'b100);
    req1 = 3'b011;
    #1;
    chk("prio rr unchanged", 32'(gnt1), 32'b001);
    step();
    req1 = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
